// File: rtl/adder_pkg.sv
// Shared constants and helpers for the ripple-carry adder.
// Provides MAX_WIDTH and the full-sum width helper (WIDTH+1).
package adder_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int sum_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder, the bit-slice leaf of the ripple chain.
// Ports: a, b, ci in; y = sum bit, co = carry to the next slice.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic y,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign y  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with a combinational sum and a registered copy.
// Ports: clk, rst_n (async low), A, B, CI, in_valid -> Y, CO, Y_r, CO_r, out_valid.
module full_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic [WIDTH-1:0] Y_r,
    output logic             CO_r,
    output logic             out_valid
);

    localparam int SW = sum_width(WIDTH);

    logic [WIDTH:0]  c;
    logic [SW-1:0]   sum;

    assign c[0] = CI;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        fa_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .y  (Y[i]),
            .co (c[i+1])
        );
    end

    assign CO  = c[WIDTH];
    assign sum = {CO, Y};

    // Capture only qualified inputs; out_valid marks the cycle after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_r       <= '0;
            CO_r      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y_r  <= sum[WIDTH-1:0];
                CO_r <= sum[SW-1];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16.
// Directed truth-table, carry-chain and reset checks plus a random scoreboard.
module tb_full_adder;

    logic clk;
    int   n_chk;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic rst1, a1, b1, ci1, v1, y1, co1, yr1, cor1, ov1;
    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst1), .A(a1), .B(b1), .CI(ci1), .in_valid(v1),
        .Y(y1), .CO(co1), .Y_r(yr1), .CO_r(cor1), .out_valid(ov1)
    );

    // WIDTH=8 instance
    logic       rst8, ci8, v8, co8, cor8, ov8;
    logic [7:0] a8, b8, y8, yr8;
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8), .A(a8), .B(b8), .CI(ci8), .in_valid(v8),
        .Y(y8), .CO(co8), .Y_r(yr8), .CO_r(cor8), .out_valid(ov8)
    );

    // WIDTH=16 instance
    logic        rst16, ci16, v16, co16, cor16, ov16;
    logic [15:0] a16, b16, y16, yr16;
    full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst16), .A(a16), .B(b16), .CI(ci16), .in_valid(v16),
        .Y(y16), .CO(co16), .Y_r(yr16), .CO_r(cor16), .out_valid(ov16)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for the WIDTH=16 registered path
    logic [16:0] sb_q[$];
    logic [16:0] last_exp;
    logic [16:0] got;

    initial last_exp = '0;

    always @(negedge clk) begin
        if (rst16) begin
            got = {cor16, yr16};
            if (ov16) begin
                if (sb_q.size() == 0) begin
                    check("w16_unexpected_valid", 64'(ov16), 64'd0);
                end else begin
                    last_exp = sb_q.pop_front();
                    check("w16_registered", 64'(got), 64'(last_exp));
                end
            end else begin
                check("w16_hold", 64'(got), 64'(last_exp));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [1:0] tt [8];
    int          s;
    logic [16:0] ref16;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        // {Y,CO} indexed by {A,B,CI}
        tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;

        rst1 = 0; rst8 = 0; rst16 = 0;
        a1 = 0; b1 = 0; ci1 = 0; v1 = 0;
        a8 = 0; b8 = 0; ci8 = 0; v8 = 0;
        a16 = 0; b16 = 0; ci16 = 0; v16 = 0;
        #1;
        check("reset_w1", {61'd0, yr1, cor1, ov1}, 64'd0);
        check("reset_w8", {55'd0, yr8, cor8, ov8}, 64'd0);
        check("reset_w16", {47'd0, yr16, cor16, ov16}, 64'd0);

        // Truth table, unclocked
        for (int i = 0; i < 8; i++) begin
            {a1, b1, ci1} = 3'(i);
            #5;
            check($sformatf("tt_%0d", i), 64'({y1, co1}), 64'(tt[i]));
        end

        @(negedge clk);
        #1;
        rst1 = 1; rst8 = 1; rst16 = 1;

        // WIDTH=1 clocked capture then hold
        a1 = 1; b1 = 1; ci1 = 0; v1 = 1;
        @(negedge clk);
        check("w1_cap", 64'({yr1, cor1, ov1}), 64'(3'b011));
        #1;
        v1 = 0; a1 = 0; b1 = 0;
        @(negedge clk);
        check("w1_hold", 64'({yr1, cor1, ov1}), 64'(3'b010));

        // WIDTH=8 carry chain
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1; #1;
        check("w8_ff_ci", 64'({co8, y8}), 64'h100);
        a8 = 8'h80; b8 = 8'h80; ci8 = 0; #1;
        check("w8_msb", 64'({co8, y8}), 64'h100);
        a8 = 8'h0F; b8 = 8'h01; ci8 = 0; #1;
        check("w8_nibble", 64'({co8, y8}), 64'h010);

        // Async reset mid-cycle
        @(negedge clk); #1;
        a8 = 8'h5A; b8 = 8'h00; ci8 = 0; v8 = 1;
        @(negedge clk);
        check("w8_pre_rst", 64'({yr8, cor8, ov8}), 64'({8'h5A, 2'b01}));
        #2;
        rst8 = 0;
        #1;
        check("w8_async_rst", 64'({yr8, cor8, ov8}), 64'd0);
        a8 = 8'h11; #1;
        check("w8_comb_in_rst", 64'({co8, y8}), 64'h011);

        // Release with valid input pending
        a8 = 8'd3; b8 = 8'd4; ci8 = 1; v8 = 1;
        @(negedge clk); #3;
        check("w8_still_rst", 64'({yr8, cor8, ov8}), 64'd0);
        rst8 = 1;
        @(negedge clk);
        check("w8_release", 64'({yr8, cor8, ov8}), 64'({8'h08, 2'b01}));
        #1; v8 = 0;

        // Random WIDTH=16
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #1;
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            ci16 = 1'($urandom);
            v16  = ($urandom_range(0, 3) != 0);
            s     = int'(a16) + int'(b16) + int'(ci16);
            ref16 = 17'(s);
            #1;
            check("w16_comb", 64'({co16, y16}), 64'(ref16));
            if (v16) sb_q.push_back(ref16);
        end
        @(negedge clk); #1;
        v16 = 0;
        @(negedge clk);
        @(negedge clk);
        check("w16_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable ripple-carry adder: Y + CO = A + B + CI.
- Combinational sum/carry outputs with zero latency, plus a registered copy with a valid flag for pipelined consumers.
- WIDTH=1 is the classic 1-bit full adder used as the arithmetic leaf in datapath blocks.
- Wider instances chain bit-slice cells.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- CI  input  1  carry in to bit 0
- in_valid  input  1  qualifies A/B/CI for capture into the output register
- Y  output  WIDTH  combinational sum, (A+B+CI) mod 2^WIDTH
- CO  output  1  combinational carry out of the MSB
- Y_r  output  WIDTH  registered Y
- CO_r  output  1  registered CO
- out_valid  output  1  Y_r/CO_r hold a result captured from a valid input

Behaviour:
- Combinational path:
  - Y and CO depend only on A, B and CI; no clock or reset involvement.
  - Must settle within one input change (no latches, no feedback).
- Bit-slice equations:
  - y[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i]))
  - c[0] = CI; CO = c[WIDTH].
- WIDTH=1 truth table (A B CI -> Y CO):
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- Arithmetic is unsigned. {CO,Y} is the exact WIDTH+1-bit sum; no saturation or overflow flag.
- Registered path:
  - On rising clk with in_valid=1: Y_r<=Y, CO_r<=CO, out_valid<=1. Latency is 1 cycle.
  - On rising clk with in_valid=0: Y_r/CO_r hold their values; out_valid<=0.
- Reset:
  - rst_n low asynchronously forces Y_r=0, CO_r=0, out_valid=0 immediately, regardless of clk.
  - Release is synchronous-safe: the first capture occurs on the first rising edge after rst_n goes high.
  - Reset asserted mid-stream discards the pending result. Combinational Y/CO are unaffected by reset.
- X/unknown on any input propagates; no input sanitizing.
- No handshake backpressure: every valid input is accepted each cycle.

Decomposition:
- Shared package (adder_pkg):
  - MAX_WIDTH=64 constant
  - localparam-style helper for sum width (WIDTH+1)
- Sub-module fa_cell: 1-bit combinational full adder (ports a, b, ci, y, co).
- Top generates WIDTH fa_cell instances in a ripple chain, followed by the output register stage.

Test Plan:
- WIDTH=1, in_valid=0: apply all 8 A/B/CI combinations, 5 ns apart -> Y/CO match the truth table above at each step (e.g. 011 -> Y=0, CO=1; 111 -> Y=1, CO=1).
- WIDTH=1, clocked: drive A=1, B=1, CI=0 with in_valid=1 for one edge -> next cycle Y_r=0, CO_r=1, out_valid=1. Deassert in_valid -> out_valid=0 and Y_r/CO_r hold 0/1.
- WIDTH=8 carry chain:
  - A=0xFF, B=0x00, CI=1 -> Y=0x00, CO=1.
  - A=0x80, B=0x80, CI=0 -> Y=0x00, CO=1.
  - A=0x0F, B=0x01, CI=0 -> Y=0x10, CO=0.
- Async reset: with out_valid=1 and Y_r=0x5A, pull rst_n low between edges -> Y_r=0, CO_r=0, out_valid=0 immediately. Combinational Y still tracks inputs.
- Reset release: deassert rst_n with in_valid=1, A=3, B=4, CI=1 (WIDTH=8) -> first rising edge after release gives Y_r=0x08, CO_r=0, out_valid=1.
- Random WIDTH=16: 1000 random A/B/CI -> {CO,Y} equals the 17-bit reference sum every cycle; registered outputs equal the previous cycle's combinational result when in_valid was 1.
